// File: rtl/uart_mem_loader.sv
// Serial boot loader: unpacks SYNC/LEN/payload/CSUM frames from the UART into
// little-endian 32-bit word stores, holding the CPU off the bus for the whole frame.
module uart_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        mem_ack,
  output logic        store_enable,
  output logic        is_sw,
  output logic [31:0] address,
  output logic [31:0] data_out,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [10:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        store_en_q, store_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [15:0] len_full;
  logic [10:0] next_word;
  logic [31:0] asm_shift;

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, len_q[7:0]};
  assign next_word = word_idx_q + 11'd1;
  // First byte of a word ends up in bits [7:0] after four right-shifts.
  assign asm_shift = {rx_data, asm_q[31:8]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    store_en_d = store_en_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: if (accept && rx_data == SYNC_BYTE) begin
        state_d    = S_LEN0;
        hold_d     = 1'b1;
        csum_d     = 8'h00;
        word_idx_d = 11'd0;
        asm_d      = 32'h0;
        byte_cnt_d = 2'd0;
      end
      S_LEN0: if (accept) begin
        len_d[7:0] = rx_data;
        state_d    = S_LEN1;
      end
      S_LEN1: if (accept) begin
        len_d = len_full;
        if ({1'b0, len_full} > MAX_LEN) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          hold_d  = 1'b0;
        end else if (len_full == 16'd0) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (accept) begin
        asm_d      = asm_shift;
        csum_d     = csum_q ^ rx_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          state_d    = S_WRITE;
          store_en_d = 1'b1;
          addr_d     = BASE_ADDR + {19'd0, word_idx_q, 2'b00};
          data_d     = asm_shift;
        end
      end
      S_WRITE: if (mem_ack) begin
        store_en_d = 1'b0;
        word_idx_d = next_word;
        state_d    = ({5'd0, next_word} == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (accept) begin
        hold_d = 1'b0;
        if (rx_data == csum_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      word_idx_q <= 11'd0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 32'h0;
      csum_q     <= 8'h00;
      store_en_q <= 1'b0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      store_en_q <= store_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign store_enable = store_en_q;
  assign is_sw        = store_en_q;
  assign address      = addr_q;
  assign data_out     = data_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: stimulus queues expected stores and
// done/error events; a negedge monitor pops and compares them as they appear.
module tb_uart_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_ack = 1'b0;
  logic        store_enable, is_sw, cpu_hold, done, error;
  logic [31:0] address, data_out;

  uart_mem_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_ack(mem_ack), .store_enable(store_enable), .is_sw(is_sw), .address(address),
    .data_out(data_out), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;   // expected store_enable cycles, <=0 means unchecked
  } st_t;
  typedef logic [7:0] bq_t[$];

  st_t exp_st[$];
  int  exp_ev[$];        // 0 = done, 1 = error
  int  total = 0;
  int  bad = 0;
  int  ack_delay = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay cycles of store_enable.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (store_enable) begin
        cnt++;
        mem_ack = (cnt > ack_delay);
      end else begin
        cnt = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    st_t cur;
    int  hold_cnt = 0;
    int  ev;
    logic prev_se = 1'b0;
    logic prev_hold = 1'b0;
    cur.addr = '0; cur.data = '0; cur.hold = 0;
    forever begin
      @(negedge clk);
      if (store_enable) begin
        if (!prev_se) begin
          if (exp_st.size() == 0) begin
            chk("unexpected_store", 32'd1, 32'd0);
            cur.hold = 0;
          end else begin
            cur = exp_st.pop_front();
          end
          hold_cnt = 0;
          $display("store addr=%h data=%h", address, data_out);
        end
        hold_cnt++;
        chk("st_addr", address, cur.addr);
        chk("st_data", data_out, cur.data);
        chk("st_is_sw", {31'd0, is_sw}, 32'd1);
        chk("st_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("st_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      end else if (prev_se && cur.hold > 0) begin
        chk("st_hold_len", hold_cnt, cur.hold);
      end
      if (done || error) begin
        $display("event done=%0d error=%0d", done, error);
        if (exp_ev.size() == 0) begin
          chk("unexpected_event", {30'd0, error, done}, 32'd0);
        end else begin
          ev = exp_ev.pop_front();
          chk("ev_kind", {30'd0, error, done}, (ev == 1) ? 32'd2 : 32'd1);
          chk("ev_cpu_hold", {31'd0, cpu_hold}, 32'd0);
          chk("ev_prev_hold", {31'd0, prev_hold}, 32'd1);
          chk("ev_rx_ready", {31'd0, rx_ready}, 32'd0);
        end
      end
      prev_se = store_enable;
      prev_hold = cpu_hold;
    end
  end

  task automatic send_bytes(input bq_t bytes);
    foreach (bytes[i]) begin
      int n = 0;
      rx_valid = 1'b1;
      rx_data = bytes[i];
      while (!rx_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        chk("rx_timeout", 32'd1, 32'd0);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_st.size() != 0 || exp_ev.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, n >= 400}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input int h);
    st_t s;
    s.addr = a; s.data = d; s.hold = h;
    exp_st.push_back(s);
  endtask

  initial begin
    bq_t fr;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_store_en", {31'd0, store_enable}, 32'd0);
    chk("rst_is_sw", {31'd0, is_sw}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_flags", {29'd0, cpu_hold, done, error}, 32'd0);

    // Nominal: XOR of 11 22 33 44 AA BB CC DD = 0x44.
    fr = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    push_st(32'h0, 32'h44332211, 1);
    push_st(32'h4, 32'hDDCCBBAA, 1);
    exp_ev.push_back(0);
    send_bytes(fr);
    drain();

    // Bad checksum: stores still happen, then error.
    fr = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
    push_st(32'h0, 32'h44332211, 1);
    push_st(32'h4, 32'hDDCCBBAA, 1);
    exp_ev.push_back(1);
    send_bytes(fr);
    drain();

    // LEN = 1025 is rejected straight after LEN_HI.
    fr = {8'hA5, 8'h01, 8'h04};
    exp_ev.push_back(1);
    send_bytes(fr);
    drain();

    // Empty frame: checksum of no bytes is 0.
    fr = {8'hA5, 8'h00, 8'h00, 8'h00};
    exp_ev.push_back(0);
    send_bytes(fr);
    drain();

    // Backpressure: ack after 5 wait cycles, store held 6 cycles.
    ack_delay = 5;
    fr = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    push_st(32'h0, 32'h44332211, 6);
    push_st(32'h4, 32'hDDCCBBAA, 6);
    exp_ev.push_back(0);
    send_bytes(fr);
    drain();
    ack_delay = 0;

    // Garbage before sync, A5 inside payload: A5^12^34^56 = 0xD5.
    fr = {8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5};
    push_st(32'h0, 32'h563412A5, 1);
    exp_ev.push_back(0);
    send_bytes(fr);
    drain();

    // Reset while a store is pending.
    ack_delay = 50;
    fr = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    push_st(32'h0, 32'h44332211, 0);
    send_bytes(fr);
    n = 0;
    while (!store_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_store", {31'd0, store_enable}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_store_en", {31'd0, store_enable}, 32'd0);
    chk("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("mid_rst_addr_data", address | data_out, 32'd0);
    ack_delay = 0;
    repeat (3) @(negedge clk);

    fr = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    push_st(32'h0, 32'h44332211, 1);
    push_st(32'h4, 32'hDDCCBBAA, 1);
    exp_ev.push_back(0);
    send_bytes(fr);
    drain();

    chk("left_stores", exp_st.size(), 32'd0);
    chk("left_events", exp_ev.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
